led_tick_gen: RTL

- Upstream timing stage for the LED pattern blocks: turns the 100 MHz board clock into a 1-cycle-wide enable pulse (tick) at a user-selectable rate.
- The rate steps 1/2/4/8 Hz from a debounced push button; a run switch pauses the pattern.
- Consumers stay on clk_in and advance only on tick. The optional square-wave output serves shifters that still take a derived clock.

---
 rtl/led_tick_gen.sv | 101 ++++++++++
 1 files changed

// File: rtl/led_tick_gen.sv
// led_tick_gen: rate-selectable tick enable with a debounced speed button and a run/pause switch.
// Define LED_TICK_GEN_CLKOUT_EN to add the clk_div square-wave output.
module led_tick_gen #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = 27
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_speed,
    input  logic       run,
`ifdef LED_TICK_GEN_CLKOUT_EN
    output logic       clk_div,
`endif
    output logic       tick,
    output logic [1:0] rate_sel,
    output logic       btn_evt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLK_P = CNT_W'(CLK_HZ);

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       btn_sync, run_sync;
    logic [DW-1:0]    dcnt, dcnt_nxt;
    logic [CNT_W-1:0] cnt, period;
    logic             btn, run_s, press, wrap;

    assign btn     = btn_sync[1];
    assign run_s   = run_sync[1];
    assign press   = (state == PRESSED);
    assign btn_evt = press;
    assign period  = CLK_P >> rate_sel;
    assign wrap    = run_s && (cnt == period - 1'b1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            btn_sync <= '0;
            run_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn_speed};
            run_sync <= {run_sync[0], run};
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt + 1'b1;
        case (state)
            IDLE: begin
                state_nxt = btn ? WAIT_PRESS : IDLE;
                dcnt_nxt  = '0;
            end
            WAIT_PRESS: state_nxt = !btn ? IDLE : (dcnt == D_LAST) ? PRESSED : WAIT_PRESS;
            PRESSED: begin
                state_nxt = WAIT_RELEASE;
                dcnt_nxt  = '0;
            end
            default: begin
                state_nxt = (!btn && dcnt == D_LAST) ? IDLE : WAIT_RELEASE;
                dcnt_nxt  = btn ? '0 : dcnt + 1'b1;
            end
        endcase
    end

    // A rate change restarts the period and swallows any coincident tick.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dcnt     <= '0;
            cnt      <= '0;
            tick     <= 1'b0;
            rate_sel <= 2'd0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            tick  <= wrap && !press;
            if (press) begin
                cnt      <= '0;
                rate_sel <= rate_sel + 1'b1;
            end else if (wrap) begin
                cnt <= '0;
            end else if (run_s) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef LED_TICK_GEN_CLKOUT_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            clk_div <= 1'b0;
        else if (press)
            clk_div <= 1'b0;
        else if (run_s && (cnt == (period >> 1) - 1'b1 || cnt == period - 1'b1))
            clk_div <= ~clk_div;
    end
`endif
endmodule
